// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// The requester drives start/a/b; the subtractor returns status and the registered result.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first,
// using a single full-adder cell on a and ~b with the carry flop preset to 1.
module serial_subtractor #(
  parameter int unsigned WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] sh_r_q, sh_r_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic sum_bit;
  logic carry_next;
  logic accept;

  always_comb begin
    state_d    = state_q;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    sh_r_d     = sh_r_q;
    cnt_d      = cnt_q;
    c_d        = c_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    diff_d     = diff_q;
    bout_d     = bout_q;
    ovf_d      = ovf_q;

    sum_bit    = sh_a_q[0] ^ sh_b_q[0] ^ c_q;
    carry_next = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & c_q) | (sh_b_q[0] & c_q);
    accept     = (state_q != StRun) && bus.start;

    unique case (state_q)
      StIdle: state_d = StIdle;
      StRun: begin
        sh_a_d = sh_a_q >> 1;
        sh_b_d = sh_b_q >> 1;
        sh_r_d = {sum_bit, sh_r_q[WIDTH-1:1]};
        c_d    = carry_next;
        if (cnt_q == CntLast) begin
          // Final bit: publish the full result in one edge so no partial value is visible.
          cnt_d   = '0;
          diff_d  = {sum_bit, sh_r_q[WIDTH-1:1]};
          bout_d  = ~carry_next;
          ovf_d   = (a_msb_q != b_msb_q) && (sum_bit != a_msb_q);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      sh_a_d  = bus.a;
      sh_b_d  = ~bus.b;
      sh_r_d  = '0;
      c_d     = 1'b1;
      cnt_d   = '0;
      a_msb_d = bus.a[WIDTH-1];
      b_msb_d = bus.b[WIDTH-1];
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_r_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_r_q  <= sh_r_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule
